// File: rtl/rr_mux_n_pkg.sv
// Shared types and helpers for the N-way registered multiplexer family.
package mux_pkg;

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Width of a channel index: never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Low bit of channel idx inside a flattened {ch[N-1], ..., ch[0]} bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Valid/ready bundle between N producers, the mux and one consumer.
interface rr_mux_n_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4
);
  import mux_pkg::*;

  localparam int unsigned SEL_W = sel_w(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;

  // Producer/consumer side of the bundle.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_valid,
    output out_ready
  );

  // Mux side of the bundle.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_sel,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/rr_mux_n_arbiter.sv
// Round-robin arbiter: owns the priority pointer and produces a one-hot
// grant plus its binary index.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] cand;
  logic             found;
  int unsigned      srch_idx;

  // Scan ptr, ptr+1, ... with wrap at N; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    srch_idx  = 0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      srch_idx = 32'(ptr_q) + k;
      if (srch_idx >= N) begin
        srch_idx = srch_idx - N;
      end
      cand = SEL_W'(srch_idx);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next priority is the channel after the winner; wrap explicitly so a
  // non-power-of-2 N never yields an index of N or above.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (grant_idx == SEL_W'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SEL_W'(1);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel round-robin multiplexer with a one-entry registered output.
module rr_mux_n
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4
) (
  input  logic      clk,
  input  logic      reset,
  rr_mux_n_if.slave bus
);

  localparam int unsigned SEL_W = sel_w(N);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] sel_data;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             load;
  logic             advance;

  // Register can take a word when empty or when the consumer drains it now.
  assign load    = (state_q == OUT_EMPTY) | bus.out_ready;
  // Reset gating keeps in_ready low while reset is held even though the
  // empty register would otherwise report load.
  assign advance = ~reset & load & (|bus.in_valid);

  assign bus.in_ready  = {N{advance}} & grant;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = (state_q == OUT_FULL);

  rr_arbiter_n #(.N(N)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.in_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot AND-OR select over the N input slices.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_data = sel_data |
                 (bus.in_data[slice_lo(i, WIDTH) +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Load a granted word, or empty on a drain with nothing to replace it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (advance) begin
      state_d = OUT_FULL;
      data_d  = sel_data;
      sel_d   = grant_idx;
    end else if ((state_q == OUT_FULL) && bus.out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: an N=4 and an N=3 instance checked every cycle
// against a behavioural round-robin model, plus directed literal cases.
module tb_rr_mux_n;

  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Stimulus: index 0 drives the N=4 instance, index 1 the N=3 instance.
  logic [3:0]   v    [2];
  logic [W-1:0] d    [2][4];
  logic         ordy [2];

  rr_mux_n_if #(.WIDTH(W), .N(4)) bus4 ();
  rr_mux_n_if #(.WIDTH(W), .N(3)) bus3 ();

  assign bus4.in_valid  = v[0];
  assign bus4.in_data   = {d[0][3], d[0][2], d[0][1], d[0][0]};
  assign bus4.out_ready = ordy[0];
  assign bus3.in_valid  = v[1][2:0];
  assign bus3.in_data   = {d[1][2], d[1][1], d[1][0]};
  assign bus3.out_ready = ordy[1];

  rr_mux_n #(.WIDTH(W), .N(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  rr_mux_n #(.WIDTH(W), .N(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Behavioural model state.
  logic         m_full [2];
  logic [W-1:0] m_data [2];
  logic [1:0]   m_sel  [2];
  logic [1:0]   m_ptr  [2];

  int checks = 0;
  int errors = 0;

  function automatic int nch(input logic k);
    return k ? 3 : 4;
  endfunction

  // First valid channel in order ptr, ptr+1, ... modulo n; -1 when none.
  function automatic int exp_grant(input logic k);
    for (int off = 0; off < nch(k); off++) begin
      int i;
      i = (int'(m_ptr[k]) + off) % nch(k);
      if (v[k][2'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input logic k);
    int g;
    g = exp_grant(k);
    if (reset || (m_full[k] && !ordy[k]) || g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  // Model update on each edge; reset clears at once.
  always @(posedge clk or posedge reset) begin
    for (int kk = 0; kk < 2; kk++) begin
      if (reset) begin
        m_full[1'(kk)] <= 1'b0;
        m_data[1'(kk)] <= '0;
        m_sel[1'(kk)]  <= '0;
        m_ptr[1'(kk)]  <= '0;
      end else if ((!m_full[1'(kk)] || ordy[1'(kk)]) && exp_grant(1'(kk)) >= 0) begin
        m_full[1'(kk)] <= 1'b1;
        m_data[1'(kk)] <= d[1'(kk)][2'(exp_grant(1'(kk)))];
        m_sel[1'(kk)]  <= 2'(exp_grant(1'(kk)));
        m_ptr[1'(kk)]  <= 2'((exp_grant(1'(kk)) + 1) % nch(1'(kk)));
      end else if (m_full[1'(kk)] && ordy[1'(kk)]) begin
        m_full[1'(kk)] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Compare both instances against the model.
  task automatic model_cmp();
    chk("n4.in_ready",  W'(bus4.in_ready),          W'(exp_ready(1'b0)));
    chk("n4.out_valid", W'(bus4.out_valid),         W'(m_full[0]));
    chk("n4.out_data",  bus4.out_data,              m_data[0]);
    chk("n4.out_sel",   W'(bus4.out_sel),           W'(m_sel[0]));
    chk("n3.in_ready",  W'({1'b0, bus3.in_ready}),  W'(exp_ready(1'b1)));
    chk("n3.out_valid", W'(bus3.out_valid),         W'(m_full[1]));
    chk("n3.out_data",  bus3.out_data,              m_data[1]);
    chk("n3.out_sel",   W'(bus3.out_sel),           W'(m_sel[1]));
  endtask

  task automatic step();
    @(negedge clk);
    model_cmp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] acc [2];
    int seq [5];
    seq = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    v[0] = 4'b1111;
    v[1] = 4'b0000;
    ordy[0] = 1'b0;
    ordy[1] = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        d[1'(k)][2'(i)] = W'(i + 1);

    // Reset state with inputs valid.
    step();
    step();
    chk("rst.in_ready",  W'(bus4.in_ready),  W'(4'b0000));
    chk("rst.out_valid", W'(bus4.out_valid), W'(0));
    chk("rst.out_data",  bus4.out_data,      W'(0));
    chk("rst.out_sel",   W'(bus4.out_sel),   W'(0));

    // Single channel.
    reset   = 1'b0;
    v[0]    = 4'b0100;
    d[0][2] = W'(100);
    ordy[0] = 1'b1;
    #1;
    chk("single.in_ready", W'(bus4.in_ready), W'(4'b0100));
    step();
    chk("single.out_data",  bus4.out_data,      W'(100));
    chk("single.out_sel",   W'(bus4.out_sel),   W'(2));
    chk("single.out_valid", W'(bus4.out_valid), W'(1));

    // Priority now starts at channel 3.
    v[0] = 4'b1111;
    for (int i = 0; i < 4; i++) d[0][2'(i)] = W'(10 + i);
    #1;
    chk("prio.in_ready", W'(bus4.in_ready), W'(4'b1000));
    step();
    chk("prio.out_sel", W'(bus4.out_sel), W'(3));

    // Fair rotation.
    for (int s = 0; s < 5; s++) begin
      step();
      chk("rot.out_sel",   W'(bus4.out_sel),   W'(seq[s]));
      chk("rot.out_data",  bus4.out_data,      W'(10 + seq[s]));
      chk("rot.out_valid", W'(bus4.out_valid), W'(1));
    end
    step();
    chk("rot.out_sel1", W'(bus4.out_sel), W'(1));

    // Backpressure with everything valid.
    ordy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp.in_ready", W'(bus4.in_ready), W'(4'b0000));
      chk("bp.out_data", bus4.out_data,     W'(11));
      chk("bp.out_sel",  W'(bus4.out_sel),  W'(1));
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp.release_ready", W'(bus4.in_ready), W'(4'b0100));
    step();
    chk("bp.next_sel", W'(bus4.out_sel), W'(2));

    // Drain to empty.
    v[0] = 4'b0000;
    step();
    chk("drain.out_valid", W'(bus4.out_valid), W'(0));
    chk("drain.out_sel",   W'(bus4.out_sel),   W'(2));
    chk("drain.out_data",  bus4.out_data,      W'(12));

    // Reset between edges while holding 0x55.
    v[0]    = 4'b0001;
    d[0][0] = W'(64'h55);
    step();
    chk("rmid.out_data", bus4.out_data, W'(64'h55));
    v[0]    = 4'b0000;
    ordy[0] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rmid.out_valid", W'(bus4.out_valid), W'(0));
    chk("rmid.out_data",  bus4.out_data,      W'(0));
    step();
    reset = 1'b0;

    // N=3 wrap from channel 2 to 0.
    v[1]    = 4'b0100;
    d[1][2] = W'(7);
    ordy[1] = 1'b1;
    #1;
    chk("n3.wrap_ready2", W'(bus3.in_ready), W'(3'b100));
    step();
    chk("n3.wrap_sel2", W'(bus3.out_sel), W'(2));
    v[1] = 4'b0111;
    for (int i = 0; i < 3; i++) d[1][2'(i)] = W'(20 + i);
    #1;
    chk("n3.wrap_ready0", W'(bus3.in_ready), W'(3'b001));
    step();
    chk("n3.wrap_sel0",  W'(bus3.out_sel), W'(0));
    chk("n3.wrap_data0", bus3.out_data,    W'(20));

    // Randomised traffic; producers hold valid words until accepted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      model_cmp();
      acc[0] = exp_ready(1'b0);
      acc[1] = exp_ready(1'b1);
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        ordy[1'(k)] = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < nch(1'(k)); i++) begin
          if (!(v[1'(k)][2'(i)] && !acc[1'(k)][2'(i)])) begin
            v[1'(k)][2'(i)] = 1'($urandom_range(0, 1));
            d[1'(k)][2'(i)] = {$urandom, $urandom};
          end
        end
      end
    end
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
# rr_mux_n

Parametrised N-channel, WIDTH-bit registered multiplexer. It selects one of N valid/ready input channels with a fair round-robin arbiter and holds the chosen word in a one-entry output register. It generalises the combinational 2:1 mux to N channels and adds flow control, fairness and a registered output. It is used wherever several producers (register-file ports, forwarding sources, memory requesters) share one downstream consumer.

## Interface
- WIDTH, 64: data width per channel, ≥1
- N, 4: number of input channels, ≥2
- SEL_W, $clog2(N): width of the channel-index output; derived, not overridden
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i offers a word
- in_ready  output  N  channel i's word is taken this cycle
- out_data  output  WIDTH  registered selected word
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer takes the word this cycle

## Operation
- Handshake rules:
  - A transfer occurs on any port where valid & ready are both high at a rising edge.
  - A producer holding valid keeps its data stable until it is accepted.
- The output register has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- load = ~out_valid | out_ready. When load is high, the register may capture a new word this cycle.
- Arbiter:
  - ptr (SEL_W bits) is the highest-priority channel.
  - Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - grant is one-hot on the first channel in that order with in_valid set. It is all-zero if no input is valid.
- in_ready[i] = load & grant[i]. At most one bit is ever high. in_ready is combinational from in_valid, out_valid and out_ready.
- On a transfer from channel g:
  - out_data ← in_data[g]; out_sel ← g; out_valid ← 1.
  - ptr ← (g+1) mod N. Wrap from N-1 goes to 0. Non-power-of-2 N must never produce an index ≥ N.
- Drain with no new grant (out_valid & out_ready & no input valid):
  - out_valid ← 0.
  - out_data and out_sel keep their last values.
  - ptr is unchanged.
- Simultaneous drain and load: the new word replaces the old in the same edge. out_valid stays 1, giving full throughput of one word per cycle.
- FULL & ~out_ready: no input is accepted, and out_data, out_sel and ptr hold.
- out_ready while EMPTY has no effect.
- Fairness: with all N channels continuously valid and out_ready=1, grants rotate 0,1,…,N-1,0,… with no channel granted twice within N transfers.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0 while reset is high.
- Reset is asynchronous. Asserting it mid-operation discards the held word on assertion, not at the next edge.
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k (one cycle).
- Throughput: one word per cycle when out_ready is held high.
- in_ready has no register stage. Its combinational path runs from out_ready and in_valid.

## Structure
- Package mux_pkg holds a function sel_w(n) returning max(1, $clog2(n)), plus the channel-slice helper used by related N-way muxes.
- Sub-module rr_arbiter_n (parameter N) contains ptr, its reset and its update:
  - inputs: clk, reset, req[N], advance
  - outputs: grant[N] one-hot, grant_idx[SEL_W]
  - advance = load & |req.
- The data-path select is a one-hot AND-OR over N slices, matching the gate-level style of the 2:1 mux. It is instantiated in rr_mux_n.

## Test plan
Run all cases with N=4, WIDTH=64 unless stated otherwise.
- **Reset check:** hold reset, drive in_valid=4'b1111 → out_valid=0, in_ready=0, out_data=0, out_sel=0.
- **Reset mid-operation:** FULL with out_data=0x55, assert reset between edges → out_valid drops to 0 immediately, before the next edge.
- **Single channel:** release reset, in_valid=4'b0100, in_data[2]=64'd100, out_ready=1 → in_ready=4'b0100. After one edge, out_data=100, out_sel=2, out_valid=1. Next grant priority starts at channel 3.
- **Fair rotation:** all valid with channel i data = 10+i, out_ready=1 → out_sel sequence 0,1,2,3,0 with out_data 10,11,12,13,10, and out_valid high every cycle.
- **Backpressure:** FULL with out_data=11, out_ready=0 for 3 cycles, all inputs valid → in_ready=0, out_data stays 11 and out_sel stays 1. Raising out_ready → next out_sel=2.
- **Drain to empty and non-power-of-2 wrap:**
  - FULL, out_ready=1, no inputs valid → out_valid=0 after one edge, out_sel held.
  - With N=3, grant channel 2 → ptr wraps to 0, and out_sel never shows 3.
